adder_rr_arbiter: RTL and testbench
===================================

Name: adder_rr_arbiter

Overview:
- Shares one combinational 8-bit `full_adder` (sum + overflow) between NUM_REQ requesters in the MatrixMultiplier datapath.
- Each requester uses a valid/ready handshake. The arbiter grants one request at a time by round-robin, latches its operands and drives them to the adder.
- It captures the adder result into a registered response port and keeps a saturating count of completed operations.
- The adder is instantiated outside this block. This block only sequences and shares it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/sum width; must match the adder.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- add_a  out  WIDTH  operand A to the shared adder.
- add_b  out  WIDTH  operand B to the shared adder.
- add_sum  in  WIDTH  sum from the adder.
- add_overflow  in  1  overflow from the adder.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  $clog2(NUM_REQ)  index of the requester this response belongs to.
- resp_sum  out  WIDTH  registered sum.
- resp_overflow  out  1  registered overflow.
- busy  out  1  high in any state other than IDLE.
- ops_done  out  CNT_WIDTH  completed responses; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, ptr=0, op_a=op_b=0, op_id=0.
  - resp_valid=0, resp_id=0, resp_sum=0, resp_overflow=0, ops_done=0, busy=0.
  - req_ready=0 while rst is high.
  - An in-flight operation is dropped; no response is ever produced for it.
- add_a/add_b always equal the registers op_a/op_b. They are stable except on an accept edge.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, … modulo NUM_REQ.
  - req_ready[winner]=1, all others 0. req_ready is combinational from req_valid and ptr; no other input affects it.
  - If no req_valid is high, req_ready=0 and the FSM stays in IDLE.
  - On an edge with req_valid[w] & req_ready[w] (accept): op_a<=req_a slice w, op_b<=req_b slice w, op_id<=w, ptr<=(w+1) mod NUM_REQ, go to EXEC.
- EXEC (exactly 1 cycle):
  - req_ready=0. The adder settles on op_a/op_b.
  - At the end of the cycle: resp_sum<=add_sum, resp_overflow<=add_overflow, resp_id<=op_id, resp_valid<=1, go to RESP.
- RESP:
  - resp_valid=1; resp_* are held stable; req_ready=0.
  - On an edge with resp_ready=1: resp_valid<=0, ops_done<=ops_done+1 (holds at 2^CNT_WIDTH-1), go to IDLE.
- Latency:
  - Accept edge T; resp_valid first high after edge T+1.
  - Minimum spacing between accepts is 3 cycles (IDLE→EXEC→RESP→IDLE with resp_ready tied high).
- resp_ready is ignored in IDLE and EXEC.
- A requester that drops req_valid without being granted loses nothing; there is no lockout and no queueing.
- Operand changes after acceptance have no effect on the in-flight operation.
- Arithmetic is not done here. resp_sum and resp_overflow are bit-exact copies of the adder outputs sampled at the end of EXEC.
- busy = (state != IDLE).

Test Plan:
1. Single request, basic result:
   - Stimulus: reset, then req 0 with a=0x12, b=0x34, resp_ready=1.
   - Response: req_ready[0]=1 in the accept cycle; resp_valid one cycle after accept with resp_id=0, resp_sum=0x46, resp_overflow equal to the golden DPI model; ops_done=1.
2. Round-robin fairness:
   - Stimulus: all 4 req_valid held high, resp_ready=1, distinct operands per requester.
   - Response: grant order 0,1,2,3,0,1; one accept every 3 cycles; each resp_id matches its operands.
3. Back-pressure:
   - Stimulus: req 2 with a=0xFF, b=0x01; resp_ready=0 for 5 cycles after resp_valid rises.
   - Response: resp_sum=0x00, resp_overflow per golden model, both stable for all 5 cycles; req_ready=0 throughout; busy=1; ops_done unchanged until resp_ready=1.
4. Operand change after accept:
   - Stimulus: req 1 with a=0x80, b=0x80; after acceptance, change req_a slice 1 to 0x01.
   - Response: resp_sum=0x00 from the latched operands, resp_overflow per golden model.
5. Reset mid-operation:
   - Stimulus: assert rst asynchronously during EXEC, with ptr=3 beforehand.
   - Response: resp_valid=0 and all outputs zero immediately; no response is produced for the dropped operation. After release with reqs 0 and 3 both valid, req 0 wins (ptr=0).
6. Counter saturation:
   - Stimulus: CNT_WIDTH=2, 5 completed operations.
   - Response: ops_done sequence is 1,2,3,3,3.

Source files
------------

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one external combinational adder between NUM_REQ requesters.
// Latches the winning operands, samples the adder for one cycle and holds a registered response.
module adder_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_overflow,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_sum,
    output logic                     resp_overflow,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     ops_done
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   op_id;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [ID_W-1:0]   win;
    logic              found;

    // Scan ptr, ptr+1, ... modulo NUM_REQ; the first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        win       = '0;
        found     = 1'b0;
        req_ready = '0;
        if (state == StIdle && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    win   = idx[ID_W-1:0];
                end
            end
            if (found) req_ready[win] = 1'b1;
        end
    end

    assign add_a = op_a;
    assign add_b = op_b;
    assign busy  = (state != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            ptr           <= '0;
            op_a          <= '0;
            op_b          <= '0;
            op_id         <= '0;
            resp_valid    <= 1'b0;
            resp_id       <= '0;
            resp_sum      <= '0;
            resp_overflow <= 1'b0;
            ops_done      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (found) begin
                        op_a  <= req_a[win*WIDTH +: WIDTH];
                        op_b  <= req_b[win*WIDTH +: WIDTH];
                        op_id <= win;
                        if (win == ID_W'(NUM_REQ - 1)) ptr <= '0;
                        else ptr <= win + 1'b1;
                        state <= StExec;
                    end
                end
                StExec: begin
                    resp_sum      <= add_sum;
                    resp_overflow <= add_overflow;
                    resp_id       <= op_id;
                    resp_valid    <= 1'b1;
                    state         <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (ops_done != {CNT_WIDTH{1'b1}}) ops_done <= ops_done + 1'b1;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: stimulus queues expected grants/responses,
// negedge monitors pop and compare. A second instance with a 2-bit counter covers saturation.
module tb_adder_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           resp_ready = 1'b1;

    logic [N-1:0] req_ready, req_ready2;
    logic [W-1:0] add_a, add_b, add_sum, add_a2, add_b2, add_sum2;
    logic         add_ovf, add_ovf2;
    logic         resp_valid, resp_valid2, resp_ovf, resp_ovf2, busy, busy2;
    logic [1:0]   resp_id, resp_id2;
    logic [W-1:0] resp_sum, resp_sum2;
    logic [15:0]  ops_done;
    logic [1:0]   ops_done2;

    always #5 clk = ~clk;

    // Stand-in for the external adder: unsigned add, overflow is the carry out.
    assign {add_ovf, add_sum}   = {1'b0, add_a} + {1'b0, add_b};
    assign {add_ovf2, add_sum2} = {1'b0, add_a2} + {1'b0, add_b2};

    adder_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .add_overflow(add_ovf), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_sum(resp_sum), .resp_overflow(resp_ovf), .busy(busy),
        .ops_done(ops_done)
    );

    adder_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready2), .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
        .add_overflow(add_ovf2), .resp_valid(resp_valid2), .resp_ready(resp_ready),
        .resp_id(resp_id2), .resp_sum(resp_sum2), .resp_overflow(resp_ovf2), .busy(busy2),
        .ops_done(ops_done2)
    );

    typedef struct {
        int id;
        int sum;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_q[$];
    int   acc_cyc[$];
    int   n_acc = 0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;
    int   exp_cnt2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Grant monitor: an accept happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && |(req_valid & req_ready)) begin
            int g;
            g = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
            check("grant_twin", {28'd0, req_ready2}, {28'd0, req_ready});
            if (gnt_q.size() == 0) check("grant_queue", gnt_q.size(), 1);
            else check("grant_id", g, gnt_q.pop_front());
            n_acc++;
            acc_cyc.push_back(cyc);
        end
    end

    // Response monitor: compare on every handshake and advance the counter models.
    always @(negedge clk) begin
        if (rst) begin
            exp_cnt  = 0;
            exp_cnt2 = 0;
        end else if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_queue", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_id", {30'd0, resp_id}, e.id);
                check("resp_sum", {24'd0, resp_sum}, e.sum);
                check("resp_overflow", {31'd0, resp_ovf}, e.ovf);
                check("resp_sum_twin", {24'd0, resp_sum2}, e.sum);
            end
            check("ops_done", {16'd0, ops_done}, exp_cnt);
            check("ops_done_sat", {30'd0, ops_done2}, exp_cnt2);
            if (exp_cnt < 65535) exp_cnt = exp_cnt + 1;
            if (exp_cnt2 < 3) exp_cnt2 = exp_cnt2 + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target);
        int t;
        t = 0;
        while (n_acc < target && t < 60) begin
            step();
            t++;
        end
        if (n_acc < target) check("accept_timeout", n_acc, target);
    endtask

    task automatic wait_drain;
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            step();
            t++;
        end
        if (exp_q.size() != 0) check("resp_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        exp_q.delete();
        gnt_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] a_after, input int sum, input int ovf);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        exp_q.push_back('{id, sum, ovf});
        gnt_q.push_back(id);
        req_valid[id] = 1'b1;
        wait_acc(n_acc + 1);
        req_valid[id] = 1'b0;
        req_a[id*W +: W] = a_after;
        wait_drain();
    endtask

    initial begin
        int seq_sat[5];
        int b0;
        int t;
        seq_sat = '{1, 2, 3, 3, 3};

        // 1: reset state, then a single request
        do_reset();
        check("rst_resp_valid", {31'd0, resp_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ops_done", {16'd0, ops_done}, 0);
        do_op(0, 8'h12, 8'h34, 8'h00, 'h46, 0);
        check("t1_ops_done", {16'd0, ops_done}, 1);

        // 2: round-robin with all requesters valid
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 8'((i + 1) * 16);
            req_b[i*W +: W] = 8'(i + 1);
        end
        exp_q.push_back('{0, 'h11, 0}); exp_q.push_back('{1, 'h22, 0});
        exp_q.push_back('{2, 'h33, 0}); exp_q.push_back('{3, 'h44, 0});
        exp_q.push_back('{0, 'h11, 0}); exp_q.push_back('{1, 'h22, 0});
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2);
        gnt_q.push_back(3); gnt_q.push_back(0); gnt_q.push_back(1);
        b0 = acc_cyc.size();
        req_valid = '1;
        wait_acc(n_acc + 6);
        req_valid = '0;
        wait_drain();
        if (acc_cyc.size() >= b0 + 6)
            for (int k = 1; k < 6; k++)
                check("accept_spacing", acc_cyc[b0+k] - acc_cyc[b0+k-1], 3);

        // 4: operands changed after accept do not affect the result (ptr 2 -> 2)
        do_op(1, 8'h80, 8'h80, 8'h01, 'h00, 1);

        // 3: back-pressure on req 2
        resp_ready = 1'b0;
        req_a[2*W +: W] = 8'hFF;
        req_b[2*W +: W] = 8'h01;
        exp_q.push_back('{2, 'h00, 1});
        gnt_q.push_back(2);
        req_valid[2] = 1'b1;
        wait_acc(n_acc + 1);
        t = 0;
        while (!resp_valid && t < 10) begin
            step();
            t++;
        end
        check("bp_resp_valid", {31'd0, resp_valid}, 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_sum", {24'd0, resp_sum}, 'h00);
            check("bp_overflow", {31'd0, resp_ovf}, 1);
            check("bp_req_ready", {28'd0, req_ready}, 0);
            check("bp_busy", {31'd0, busy}, 1);
            check("bp_ops_done", {16'd0, ops_done}, exp_cnt);
            step();
        end
        resp_ready   = 1'b1;
        req_valid[2] = 1'b0;
        wait_drain();

        // 5: reset during EXEC with ptr=3; the dropped op must never respond
        req_a[0 +: W] = 8'h21;
        req_b[0 +: W] = 8'h02;
        gnt_q.push_back(0);
        req_valid[0] = 1'b1;
        wait_acc(n_acc + 1);
        #2 rst = 1'b1;
        req_valid = 4'b1001;
        req_a[0 +: W] = 8'h05; req_b[0 +: W] = 8'h06;
        req_a[3*W +: W] = 8'h07; req_b[3*W +: W] = 8'h08;
        #1;
        check("mid_rst_resp_valid", {31'd0, resp_valid}, 0);
        check("mid_rst_resp_sum", {24'd0, resp_sum}, 0);
        check("mid_rst_resp_id", {30'd0, resp_id}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_ops_done", {16'd0, ops_done}, 0);
        check("mid_rst_add_a", {24'd0, add_a}, 0);
        check("mid_rst_req_ready", {28'd0, req_ready}, 0);
        step();
        step();
        gnt_q.push_back(0);
        exp_q.push_back('{0, 'h0B, 0});
        #2 rst = 1'b0;
        wait_acc(n_acc + 1);
        req_valid = '0;
        wait_drain();
        check("post_rst_ops_done", {16'd0, ops_done}, 1);

        // 6: 2-bit counter saturates
        do_reset();
        for (int k = 0; k < 5; k++) begin
            do_op(k % N, 8'(k), 8'h01, 8'h00, k + 1, 0);
            check("sat_seq", {30'd0, ops_done2}, seq_sat[k]);
        end

        repeat (3) step();
        check("final_queues", exp_q.size() + gnt_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
